better_neighbors_in_my_cluster: RTL and testbench
=================================================

// Module: better_neighbors_in_my_cluster
// PURPOSE
// - Routing-pipeline stage after find-my-best and before winner-policy: scans the shared 16-bit neighbor table.
// - Collects every neighbor in MY_CLUSTER_ID whose Q-value beats mybest (strictly lower cost).
// - Writes their IDs and count back to memory.
// - Reports the single best such neighbor to winner-policy.
// PARAMETERS
// - WORD_WIDTH   16     data/address width
// - NEIGH_BASE   16'h48 neighborID[i] at NEIGH_BASE+2*i
// - CLUS_BASE    16'hC8 clusterID[i]
// - QVAL_BASE    16'h1C8 qValue[i]
// - BETTER_BASE  16'h668 betterneighbors[k] at BETTER_BASE+2*k
// - NCOUNT_ADDR  16'h68A neighborCount
// - BCOUNT_ADDR  16'h68C betterneighborCount
// - SCOUNT_BASE  16'h68E sinkIDCount[i]
// - MAX_BETTER   16     capacity of betterneighbors list
// PORTS
// - clock           in  1   rising-edge clock
// - nrst            in  1   asynchronous active-low reset
// - en              in  1   global enable; 0 freezes FSM and all registers
// - start           in  1   level; previous stage done
// - address         out 16  memory byte address (word-aligned)
// - wr_en           out 1   memory write strobe
// - data_in         in  16  memory read data
// - MY_CLUSTER_ID   in  16  own cluster
// - mybest          in  16  own best cost
// - besthop         out 16  neighbor-table index of best better neighbor
// - bestvalue       out 16  its qValue (mybest if none)
// - bestneighborID  out 16  its neighborID
// - nextsinks       out 16  its sinkIDCount
// - data_out        out 16  memory write data
// - done            out 1   finished; sticky until nrst
// BEHAVIOUR
// - Reset (async, nrst=0): all outputs 0, FSM IDLE, index i=0, count k=0.
// - Memory timing: read data valid on data_in one cycle after address is driven.
// - Memory timing: write occurs at the clock edge where wr_en=1; wr_en is high exactly one cycle per write.
// - FSM states and transitions:
//   - IDLE: when start&&en&&!done -> RD_N (addr NCOUNT_ADDR), latch N; bestvalue<=mybest.
//   - If N==0 -> WR_CNT.
//   - Per i: RD_C (clusterID[i]).
//   - clusterID[i]!=MY_CLUSTER_ID -> NEXT.
//   - Otherwise RD_Q; q<mybest -> RD_ID, else NEXT.
//   - RD_ID -> WR_BN: data_out=neighborID[i] to BETTER_BASE+2*k, k++.
//   - If k==MAX_BETTER, no write and no k++; the best-tracking below still applies.
//   - If q<bestvalue (strict, first wins ties): update bestvalue=q, bestneighborID, besthop=i.
//   - Then RD_S reads SCOUNT_BASE+2*i -> nextsinks.
//   - NEXT: i++; i==N (or 64) -> WR_CNT.
//   - WR_CNT: write k to BCOUNT_ADDR -> DONE.
//   - DONE: done=1, outputs held until reset; start ignored.
// - No better neighbor: bestvalue=mybest, besthop=bestneighborID=nextsinks=0, count 0 written.
// - en=0 in any state: hold state, address, data_out; wr_en forced 0; resume exactly where paused.
// - Reset mid-scan: abort immediately, outputs to reset values, no further writes.
// - All comparisons unsigned 16-bit.
// TESTING
// - N=0: start -> single write 0 to 0x68C, done=1, bestvalue=mybest.
// - N=3, clusters {1,2,1}, q {5,3,12}, IDs {7,8,9}, MY_CLUSTER_ID=1, mybest=10.
//   -> write 7 at 0x668, count 1 at 0x68C; bestneighborID=7, besthop=0, bestvalue=5.
// - Two in-cluster neighbors q {4,4}, IDs {20,21}:
//   -> both listed in order; best=20 (tie keeps first); nextsinks=sinkIDCount[0].
// - 20 better neighbors -> only 16 entries written; count 16; best still over all 20.
// - en dropped for 5 cycles mid-scan -> no writes while low; final memory identical to uninterrupted run.
// - nrst pulsed mid-scan -> outputs 0, done=0; restart with start -> correct full result.

Source files
------------

// File: rtl/better_neighbors_in_my_cluster.sv
// Better-neighbors-in-my-cluster routing stage.
// Scans the shared neighbor table, lists every neighbor in our own cluster
// whose Q-value is strictly below mybest, writes the list and its length
// back to memory, and reports the single best such neighbor.
// Memory reads are registered: data_in is valid one cycle after address is
// presented, so each read state spends one cycle presenting the address
// (phase 0) and one cycle consuming the data (phase 1).
module better_neighbors_in_my_cluster #(
  parameter int          WORD_WIDTH  = 16,
  parameter logic [15:0] NEIGH_BASE  = 16'h0048,
  parameter logic [15:0] CLUS_BASE   = 16'h00C8,
  parameter logic [15:0] QVAL_BASE   = 16'h01C8,
  parameter logic [15:0] BETTER_BASE = 16'h0668,
  parameter logic [15:0] NCOUNT_ADDR = 16'h068A,
  parameter logic [15:0] BCOUNT_ADDR = 16'h068C,
  parameter logic [15:0] SCOUNT_BASE = 16'h068E,
  parameter int          MAX_BETTER  = 16
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  start,
  output logic [WORD_WIDTH-1:0] address,
  output logic                  wr_en,
  input  logic [WORD_WIDTH-1:0] data_in,
  input  logic [WORD_WIDTH-1:0] MY_CLUSTER_ID,
  input  logic [WORD_WIDTH-1:0] mybest,
  output logic [WORD_WIDTH-1:0] besthop,
  output logic [WORD_WIDTH-1:0] bestvalue,
  output logic [WORD_WIDTH-1:0] bestneighborID,
  output logic [WORD_WIDTH-1:0] nextsinks,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  done
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_RD_N   = 4'd1,
    S_RD_C   = 4'd2,
    S_RD_Q   = 4'd3,
    S_RD_ID  = 4'd4,
    S_WR_BN  = 4'd5,
    S_RD_S   = 4'd6,
    S_NEXT   = 4'd7,
    S_WR_CNT = 4'd8,
    S_DONE   = 4'd9
  } state_e;

  localparam logic [4:0] MAX_K   = 5'(MAX_BETTER);
  localparam logic [6:0] IDX_CAP = 7'd64;

  // Byte address of word idx in a table starting at base.
  function automatic logic [15:0] word_addr(input logic [15:0] base, input logic [15:0] idx);
    return base + {idx[14:0], 1'b0};
  endfunction

  state_e      state_q, state_d;
  logic        phase_q, phase_d;
  logic [15:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [15:0] dout_q, dout_d;
  logic [6:0]  idx_q, idx_d;
  logic [15:0] n_q, n_d;
  logic [4:0]  k_q, k_d;
  logic [15:0] qv_q, qv_d;
  logic        upd_q, upd_d;
  logic [15:0] bval_q, bval_d;
  logic [15:0] bhop_q, bhop_d;
  logic [15:0] bid_q, bid_d;
  logic [15:0] nsink_q, nsink_d;
  logic        done_q, done_d;

  logic [6:0]  idx_nxt_s;
  logic        last_s;
  logic [15:0] idx_w_s;

  assign idx_nxt_s = idx_q + 7'd1;
  assign last_s    = ({9'd0, idx_nxt_s} == n_q) || (idx_nxt_s == IDX_CAP);
  assign idx_w_s   = {9'd0, idx_q};

  // Next-state and next-output computation for the scan FSM.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    addr_d  = addr_q;
    wr_d    = 1'b0;
    dout_d  = dout_q;
    idx_d   = idx_q;
    n_d     = n_q;
    k_d     = k_q;
    qv_d    = qv_q;
    upd_d   = upd_q;
    bval_d  = bval_q;
    bhop_d  = bhop_q;
    bid_d   = bid_q;
    nsink_d = nsink_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          state_d = S_RD_N;
          addr_d  = NCOUNT_ADDR;
          phase_d = 1'b0;
          bval_d  = mybest;
          idx_d   = 7'd0;
          k_d     = 5'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_N: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          n_d     = data_in;
          if (data_in == 16'd0) begin
            state_d = S_WR_CNT;
            addr_d  = BCOUNT_ADDR;
            dout_d  = {11'd0, k_q};
            wr_d    = 1'b1;
          end else begin
            state_d = S_RD_C;
            addr_d  = word_addr(CLUS_BASE, 16'd0);
          end
        end
      end
      S_RD_C: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (data_in != MY_CLUSTER_ID) begin
            state_d = S_NEXT;
          end else begin
            state_d = S_RD_Q;
            addr_d  = word_addr(QVAL_BASE, idx_w_s);
          end
        end
      end
      S_RD_Q: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          qv_d    = data_in;
          if (data_in < mybest) begin
            state_d = S_RD_ID;
            addr_d  = word_addr(NEIGH_BASE, idx_w_s);
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_RD_ID: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          // Strict compare keeps the earliest neighbor on ties.
          upd_d   = (qv_q < bval_q);
          if (qv_q < bval_q) begin
            bval_d = qv_q;
            bid_d  = data_in;
            bhop_d = idx_w_s;
          end else begin
            bval_d = bval_q;
          end
          if (k_q < MAX_K) begin
            state_d = S_WR_BN;
            addr_d  = word_addr(BETTER_BASE, {11'd0, k_q});
            dout_d  = data_in;
            wr_d    = 1'b1;
          end else if (qv_q < bval_q) begin
            state_d = S_RD_S;
            addr_d  = word_addr(SCOUNT_BASE, idx_w_s);
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_WR_BN: begin
        k_d = k_q + 5'd1;
        if (upd_q) begin
          state_d = S_RD_S;
          addr_d  = word_addr(SCOUNT_BASE, idx_w_s);
        end else begin
          state_d = S_NEXT;
        end
      end
      S_RD_S: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          nsink_d = data_in;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        idx_d = idx_nxt_s;
        if (last_s) begin
          state_d = S_WR_CNT;
          addr_d  = BCOUNT_ADDR;
          dout_d  = {11'd0, k_q};
          wr_d    = 1'b1;
        end else begin
          state_d = S_RD_C;
          addr_d  = word_addr(CLUS_BASE, {9'd0, idx_nxt_s});
        end
      end
      S_WR_CNT: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; en=0 freezes everything in place.
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      phase_q <= 1'b0;
      addr_q  <= 16'd0;
      wr_q    <= 1'b0;
      dout_q  <= 16'd0;
      idx_q   <= 7'd0;
      n_q     <= 16'd0;
      k_q     <= 5'd0;
      qv_q    <= 16'd0;
      upd_q   <= 1'b0;
      bval_q  <= 16'd0;
      bhop_q  <= 16'd0;
      bid_q   <= 16'd0;
      nsink_q <= 16'd0;
      done_q  <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      phase_q <= phase_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      dout_q  <= dout_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      k_q     <= k_d;
      qv_q    <= qv_d;
      upd_q   <= upd_d;
      bval_q  <= bval_d;
      bhop_q  <= bhop_d;
      bid_q   <= bid_d;
      nsink_q <= nsink_d;
      done_q  <= done_d;
    end
  end

  // A pending write stays armed while paused and fires once en returns.
  assign wr_en          = wr_q & en;
  assign address        = addr_q;
  assign data_out       = dout_q;
  assign besthop        = bhop_q;
  assign bestvalue      = bval_q;
  assign bestneighborID = bid_q;
  assign nextsinks      = nsink_q;
  assign done           = done_q;

endmodule

// File: tb/tb_better_neighbors_in_my_cluster.sv
// Bench for better_neighbors_in_my_cluster: word memory model, directed
// cases from the block description, and randomized tables compared with a
// behavioural model of the expected write list and best-neighbor report.
module tb_better_neighbors_in_my_cluster;

  localparam logic [15:0] NEIGH_BASE  = 16'h0048;
  localparam logic [15:0] CLUS_BASE   = 16'h00C8;
  localparam logic [15:0] QVAL_BASE   = 16'h01C8;
  localparam logic [15:0] BETTER_BASE = 16'h0668;
  localparam logic [15:0] NCOUNT_ADDR = 16'h068A;
  localparam logic [15:0] BCOUNT_ADDR = 16'h068C;
  localparam logic [15:0] SCOUNT_BASE = 16'h068E;

  logic        clock = 1'b0;
  logic        nrst, en, start;
  logic [15:0] address, data_in, myc, mybest;
  logic [15:0] besthop, bestvalue, bestid, nextsinks, data_out;
  logic        wr_en, done;

  logic [15:0] mem [0:1023];
  logic [15:0] log_a[$];
  logic [15:0] log_d[$];
  logic [15:0] e_a[$];
  logic [15:0] e_d[$];
  logic [15:0] e_val, e_hop, e_id, e_sinks;
  int          checks = 0;
  int          errors = 0;
  int          wr_while_off = 0;

  better_neighbors_in_my_cluster dut (
    .clock(clock), .nrst(nrst), .en(en), .start(start),
    .address(address), .wr_en(wr_en), .data_in(data_in),
    .MY_CLUSTER_ID(myc), .mybest(mybest),
    .besthop(besthop), .bestvalue(bestvalue), .bestneighborID(bestid),
    .nextsinks(nextsinks), .data_out(data_out), .done(done)
  );

  always #5 clock = ~clock;

  // Memory: write on wr_en, registered read one cycle after the address.
  always @(posedge clock) begin
    if (wr_en) begin
      mem[address[10:1]] <= data_out;
      log_a.push_back(address);
      log_d.push_back(data_out);
      if (!en) wr_while_off++;
    end
    data_in <= mem[address[10:1]];
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rd(input logic [15:0] a);
    return mem[a[10:1]];
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 16'd0;
  endtask

  task automatic set_nb(input int i, input logic [15:0] cl, input logic [15:0] q,
                        input logic [15:0] id, input logic [15:0] sc);
    mem[(CLUS_BASE >> 1) + i]   = cl;
    mem[(QVAL_BASE >> 1) + i]   = q;
    mem[(NEIGH_BASE >> 1) + i]  = id;
    mem[(SCOUNT_BASE >> 1) + i] = sc;
  endtask

  // Expected writes and report from the table as the rules describe it.
  task automatic model();
    int n, lim, cnt;
    logic [15:0] cl, q;
    e_a.delete(); e_d.delete();
    e_val = mybest; e_hop = 16'd0; e_id = 16'd0; e_sinks = 16'd0;
    n   = int'(rd(NCOUNT_ADDR));
    lim = (n > 64) ? 64 : n;
    cnt = 0;
    for (int i = 0; i < lim; i++) begin
      cl = mem[(CLUS_BASE >> 1) + i];
      q  = mem[(QVAL_BASE >> 1) + i];
      if (cl == myc && q < mybest) begin
        if (cnt < 16) begin
          e_a.push_back(BETTER_BASE + 16'(2 * cnt));
          e_d.push_back(mem[(NEIGH_BASE >> 1) + i]);
        end
        cnt++;
        if (q < e_val) begin
          e_val   = q;
          e_hop   = 16'(i);
          e_id    = mem[(NEIGH_BASE >> 1) + i];
          e_sinks = mem[(SCOUNT_BASE >> 1) + i];
        end
      end
    end
    e_a.push_back(BCOUNT_ADDR);
    e_d.push_back(16'((cnt > 16) ? 16 : cnt));
  endtask

  task automatic do_reset();
    nrst = 1'b0; start = 1'b0; en = 1'b1;
    repeat (2) @(posedge clock);
    #1 nrst = 1'b1;
    @(posedge clock); #1;
    log_a.delete(); log_d.delete();
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c;
    c = 0;
    start = 1'b1;
    while (!done && c < budget) begin
      @(posedge clock); #1;
      c++;
    end
    start = 1'b0;
    check({tag, "_done"}, {15'd0, done}, 16'd1);
  endtask

  task automatic compare(input string tag);
    int m;
    check({tag, "_nwr"}, 16'(log_a.size()), 16'(e_a.size()));
    m = (log_a.size() < e_a.size()) ? log_a.size() : e_a.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s_wa%0d", tag, i), log_a[i], e_a[i]);
      check($sformatf("%s_wd%0d", tag, i), log_d[i], e_d[i]);
    end
    check({tag, "_bval"}, bestvalue, e_val);
    check({tag, "_bhop"}, besthop, e_hop);
    check({tag, "_bid"}, bestid, e_id);
    check({tag, "_sinks"}, nextsinks, e_sinks);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr"}, address, 16'd0);
    check({tag, "_wr"}, {15'd0, wr_en}, 16'd0);
    check({tag, "_dout"}, data_out, 16'd0);
    check({tag, "_bval"}, bestvalue, 16'd0);
    check({tag, "_bhop"}, besthop, 16'd0);
    check({tag, "_bid"}, bestid, 16'd0);
    check({tag, "_sinks"}, nextsinks, 16'd0);
    check({tag, "_done"}, {15'd0, done}, 16'd0);
  endtask

  task automatic random_table(input int n);
    mem[NCOUNT_ADDR >> 1] = 16'(n);
    for (int i = 0; i < 64; i++)
      set_nb(i, ($urandom_range(0, 3) == 0) ? myc + 16'd1 : myc,
             16'($urandom_range(0, 2 * int'(mybest))),
             16'($urandom_range(1, 65535)), 16'($urandom_range(0, 65535)));
  endtask

  initial begin
    int lw;
    nrst = 1'b0; en = 1'b1; start = 1'b0;
    myc = 16'd1; mybest = 16'd10;
    clear_mem();
    repeat (3) @(posedge clock);
    #1 check_zero("rst");

    // N = 0: only the zero count is written.
    clear_mem(); mybest = 16'h1234; myc = 16'd1;
    do_reset(); model();
    wait_done("n0", 2000); compare("n0");

    // Three-entry example: one in-cluster better neighbor.
    clear_mem(); mybest = 16'd10; myc = 16'd1;
    mem[NCOUNT_ADDR >> 1] = 16'd3;
    set_nb(0, 16'd1, 16'd5, 16'd7, 16'd55);
    set_nb(1, 16'd2, 16'd3, 16'd8, 16'd66);
    set_nb(2, 16'd1, 16'd12, 16'd9, 16'd77);
    do_reset(); model();
    wait_done("ex3", 2000); compare("ex3");
    check("ex3_id_lit", bestid, 16'd7);
    check("ex3_val_lit", bestvalue, 16'd5);

    // Tie on q: both listed, first one kept as best.
    clear_mem(); mybest = 16'd10; myc = 16'd1;
    mem[NCOUNT_ADDR >> 1] = 16'd2;
    set_nb(0, 16'd1, 16'd4, 16'd20, 16'd33);
    set_nb(1, 16'd1, 16'd4, 16'd21, 16'd44);
    do_reset(); model();
    wait_done("tie", 2000); compare("tie");
    check("tie_sinks_lit", nextsinks, 16'd33);

    // Twenty better neighbors: list saturates at 16, best spans all 20.
    clear_mem(); mybest = 16'd100; myc = 16'd3;
    mem[NCOUNT_ADDR >> 1] = 16'd20;
    for (int i = 0; i < 20; i++)
      set_nb(i, 16'd3, 16'(90 - i * 2 + ((i == 18) ? -40 : 0)), 16'(200 + i), 16'(300 + i));
    do_reset(); model();
    wait_done("sat", 4000); compare("sat");
    check("sat_hop_lit", besthop, 16'd18);

    // en dropped for five cycles mid-scan.
    clear_mem(); mybest = 16'd500; myc = 16'd9;
    random_table(12);
    do_reset(); model();
    start = 1'b1;
    repeat (30) @(posedge clock);
    #1 en = 1'b0;
    lw = log_a.size();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("en_wr%0d", c), {15'd0, wr_en}, 16'd0);
      @(posedge clock); #1;
    end
    check("en_nolog", 16'(log_a.size()), 16'(lw));
    en = 1'b1;
    wait_done("en", 3000); compare("en");
    check("en_offwr", 16'(wr_while_off), 16'd0);

    // nrst pulsed mid-scan, then a full rerun.
    clear_mem(); mybest = 16'd300; myc = 16'd4;
    random_table(15);
    do_reset(); model();
    start = 1'b1;
    repeat (40) @(posedge clock);
    #1 nrst = 1'b0; start = 1'b0;
    #1 check_zero("mrst");
    @(posedge clock); #1 nrst = 1'b1;
    lw = log_a.size();
    repeat (5) @(posedge clock);
    #1 check("mrst_nowr", 16'(log_a.size()), 16'(lw));
    log_a.delete(); log_d.delete();
    wait_done("mrst_re", 3000); compare("mrst_re");

    // Randomized tables including N beyond the 64-entry cap.
    for (int t = 0; t < 6; t++) begin
      clear_mem();
      mybest = 16'($urandom_range(1, 1000));
      myc    = 16'($urandom_range(0, 65534));
      random_table((t == 0) ? 70 : int'($urandom_range(0, 40)));
      do_reset(); model();
      wait_done($sformatf("rnd%0d", t), 4000);
      compare($sformatf("rnd%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
